// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues inst_read at pc, hands fetched words to IF_ID, honours stall/redirect.
// Optional one-entry hold buffer for responses arriving under stall: define FETCH_BUF_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        br_take,
    input  logic [31:0] br_target,
    output logic        inst_read,
    output logic [31:0] inst_addr,
    input  logic        inst_resp,
    input  logic [31:0] inst_rdata,
    output logic        pipe_load,
    output logic [31:0] pc_out,
    output logic [31:0] ir_out,
    output logic        valid_out
);

`ifdef FETCH_BUF_EN
    typedef enum logic [1:0] {FETCH, FLUSH, HOLD} state_t;
`else
    typedef enum logic [1:0] {FETCH, FLUSH} state_t;
`endif

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] redirect, redirect_next;
`ifdef FETCH_BUF_EN
    logic [31:0] hold_ir, hold_ir_next;
    logic [31:0] hold_pc, hold_pc_next;
`endif

    assign pipe_load = ~stall_in;
    assign inst_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            redirect <= '0;
`ifdef FETCH_BUF_EN
            hold_ir  <= '0;
            hold_pc  <= '0;
`endif
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            redirect <= redirect_next;
`ifdef FETCH_BUF_EN
            hold_ir  <= hold_ir_next;
            hold_pc  <= hold_pc_next;
`endif
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        redirect_next = redirect;
`ifdef FETCH_BUF_EN
        hold_ir_next  = hold_ir;
        hold_pc_next  = hold_pc;
`endif
        inst_read     = 1'b0;
        valid_out     = 1'b0;
        pc_out        = pc;
        ir_out        = NOP_INSN;

        case (state)
            FETCH: begin
                inst_read = 1'b1;
                if (inst_resp) begin
                    if (br_take) begin
                        pc_next = br_target;
                    end else if (stall_in) begin
`ifdef FETCH_BUF_EN
                        hold_ir_next = inst_rdata;
                        hold_pc_next = pc;
                        state_next   = HOLD;
`else
                        // Word dropped; pc unchanged so the same address is requested again.
                        pc_next = pc;
`endif
                    end else begin
                        valid_out = 1'b1;
                        ir_out    = inst_rdata;
                        pc_next   = pc + 32'd4;
                    end
                end else if (br_take) begin
                    // Address must stay stable until the outstanding read completes.
                    redirect_next = br_target;
                    state_next    = FLUSH;
                end
            end

            FLUSH: begin
                inst_read = 1'b1;
                if (inst_resp) begin
                    pc_next    = br_take ? br_target : redirect;
                    state_next = FETCH;
                end else if (br_take) begin
                    redirect_next = br_target;
                end
            end

`ifdef FETCH_BUF_EN
            HOLD: begin
                if (br_take) begin
                    pc_next    = br_target;
                    state_next = FETCH;
                end else if (!stall_in) begin
                    valid_out  = 1'b1;
                    ir_out     = hold_ir;
                    pc_out     = hold_pc;
                    pc_next    = hold_pc + 32'd4;
                    state_next = FETCH;
                end
            end
`endif

            default: begin
                state_next = FETCH;
            end
        endcase

        // A response coinciding with reset is ignored and no request is issued.
        if (reset) begin
            inst_read = 1'b0;
            valid_out = 1'b0;
            ir_out    = NOP_INSN;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000060: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSN, default 32'h00000013 (addi x0,x0,0): bubble instruction.
REQ-003 SHALL have one clock; reset is synchronous and active-high (port names clk and reset).
REQ-004 Ports (name direction width meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall_in  in  1  downstream hazard; pipeline must not advance
- br_take  in  1  redirect request from EX
- br_target  in  32  redirect address
- inst_read  out  1  instruction memory read request
- inst_addr  out  32  instruction memory address
- inst_resp  in  1  read complete, inst_rdata valid this cycle
- inst_rdata  in  32  fetched word
- pipe_load  out  1  load strobe to the PC/IR/control-word pipeline shift registers
- pc_out  out  32  PC entering IF_ID
- ir_out  out  32  instruction entering IF_ID
- valid_out  out  1  pc_out/ir_out carry a real instruction (0 = bubble)

Function
REQ-005 SHALL drive pipe_load = ~stall_in combinationally every cycle.
REQ-006 SHALL hold a 32-bit pc register; inst_addr SHALL equal pc whenever inst_read=1.
REQ-007 SHALL implement states FETCH, FLUSH, HOLD (HOLD only with FETCH_BUF_EN).
REQ-008 FETCH: inst_read=1; if inst_resp=1, stall_in=0, br_take=0 -> ir_out=inst_rdata, pc_out=pc, valid_out=1, pc <= pc+4 (mod 2^32), stay FETCH.
REQ-009 FETCH, inst_resp=1, br_take=0, stall_in=1 -> with FETCH_BUF_EN capture inst_rdata/pc into hold regs, go HOLD; without it, discard word, keep pc, stay FETCH (re-request same address).
REQ-010 FETCH, inst_resp=1, br_take=1 -> discard word, valid_out=0, pc <= br_target, stay FETCH.
REQ-011 FETCH, inst_resp=0, br_take=1 -> latch br_target into redirect reg, go FLUSH; inst_addr stays at old pc (address stable until resp).
REQ-012 FLUSH: inst_read=1 at old pc; on inst_resp discard word, pc <= redirect reg, go FETCH; a further br_take in FLUSH SHALL overwrite redirect reg.
REQ-013 HOLD: inst_read=0; when stall_in=0 present held word/pc with valid_out=1, pc <= held pc+4, go FETCH; br_take in HOLD SHALL drop held word, pc <= br_target, go FETCH (br_take beats stall_in release).
REQ-014 Whenever no real instruction is presented: ir_out=NOP_INSN, pc_out=pc, valid_out=0.
REQ-015 br_take SHALL have priority over stall_in in every state.
REQ-016 No instruction SHALL be presented twice or skipped; in-order delivery only.
REQ-017 inst_rdata SHALL be ignored in any cycle with inst_resp=0.

Reset
REQ-018 On reset: pc=RESET_PC, state=FETCH, hold/redirect regs=0, valid_out=0, ir_out=NOP_INSN; inst_read=1 from the first cycle reset is low.
REQ-019 Reset mid-request SHALL abandon the request; an inst_resp in the same cycle as reset SHALL be ignored.

Configuration
REQ-020 Macro FETCH_BUF_EN: defined -> HOLD state and one-entry hold buffer present, responses under stall kept; undefined -> no HOLD, responses under stall discarded and refetched (REQ-009); all other behaviour identical.

Verification
REQ-021 Reset then inst_resp every cycle with words W0,W1,W2, stall_in=0 -> inst_addr 0x60,0x64,0x68; ir_out W0,W1,W2 with pc_out 0x60,0x64,0x68, valid_out=1.
REQ-022 Resp at 0x64 with stall_in=1 for 3 cycles -> FETCH_BUF_EN: inst_read=0 during stall, W1 presented cycle stall drops; no macro: inst_addr stays 0x64, W1 presented after re-response.
REQ-023 br_take=1, br_target=0x200 with no resp pending at 0x68 -> inst_addr held 0x68 until resp, word discarded (valid_out=0), next inst_addr=0x200.
REQ-024 br_take=1 same cycle as inst_resp at 0x68 -> valid_out=0, next inst_addr=0x200.
REQ-025 reset asserted while inst_read=1 at 0x100 with inst_resp=1 -> no valid_out, next inst_addr=0x60.
REQ-026 Latency-5 memory, stall_in=0 -> valid_out=1 once per response, ir_out=NOP_INSN/valid_out=0 otherwise, pipe_load=1 every cycle.
